cache_tag_ctrl: RTL and testbench

Lookup/replacement controller that drives the 4-way tag set (10-bit index, 37-bit tag lines) and consumes its four tag outputs. It accepts one cache request at a time, reads the indexed set, performs the hit compare, and selects a victim by valid-first then tree pseudo-LRU. On a miss it issues a fill/writeback request to memory, then writes the new tag line into the chosen way. It sits between the CPU-side request port and the tag set; data-array control keys off resp_way.

---
 rtl/cache_tag_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - 4-way tag lookup/replacement controller with tree PLRU
module cache_tag_ctrl #(
  parameter int BITS_DIRECT   = 10,
  parameter int SIZE_BIT_LINE = 37,
  parameter int TAG_W         = SIZE_BIT_LINE - 2
) (
  input  logic                     clk,
  input  logic                     gen_reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [BITS_DIRECT-1:0]   req_index,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     tags_read_enable,
  output logic [BITS_DIRECT-1:0]   tags_adress,
  output logic [SIZE_BIT_LINE-1:0] tags_data_in,
  output logic [3:0]               tags_write_enable,
  input  logic [SIZE_BIT_LINE-1:0] tags_data_out1,
  input  logic [SIZE_BIT_LINE-1:0] tags_data_out2,
  input  logic [SIZE_BIT_LINE-1:0] tags_data_out3,
  input  logic [SIZE_BIT_LINE-1:0] tags_data_out4,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [1:0]               resp_way,
  output logic                     fill_req_valid,
  output logic                     fill_req_wb,
  output logic [TAG_W-1:0]         fill_req_tag,
  output logic [BITS_DIRECT-1:0]   fill_req_index,
  input  logic                     fill_ack
);

  localparam int VB   = SIZE_BIT_LINE - 1;
  localparam int DB   = SIZE_BIT_LINE - 2;
  localparam int SETS = 1 << BITS_DIRECT;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_MISS, S_UPDATE, S_RESP
  } state_t;

  state_t                   r_state;
  logic                     r_write;
  logic [BITS_DIRECT-1:0]   r_index;
  logic [TAG_W-1:0]         r_tag;
  logic                     r_hit;
  logic [1:0]               r_way;
  logic [2:0]               r_plru [SETS];

  logic                     r_req_ready;
  logic                     r_tags_read_enable;
  logic [BITS_DIRECT-1:0]   r_tags_adress;
  logic [SIZE_BIT_LINE-1:0] r_tags_data_in;
  logic [3:0]               r_tags_write_enable;
  logic                     r_resp_valid;
  logic                     r_resp_hit;
  logic [1:0]               r_resp_way;
  logic                     r_fill_req_valid;
  logic                     r_fill_req_wb;
  logic [TAG_W-1:0]         r_fill_req_tag;
  logic [BITS_DIRECT-1:0]   r_fill_req_index;

  logic [SIZE_BIT_LINE-1:0] w_line [4];
  logic [3:0]               w_hit_vec;
  logic [3:0]               w_inv_vec;
  logic [1:0]               w_hit_way;
  logic [1:0]               w_inv_way;
  logic [1:0]               w_plru_way;
  logic [1:0]               w_victim_way;
  logic                     w_hit;
  logic                     w_victim_wb;
  logic [2:0]               w_plru;
  logic [SIZE_BIT_LINE-1:0] w_victim_line;

  assign w_line[0] = tags_data_out1;
  assign w_line[1] = tags_data_out2;
  assign w_line[2] = tags_data_out3;
  assign w_line[3] = tags_data_out4;

  // Scanning downwards leaves the lowest-index match in each way select
  always_comb begin
    w_hit_vec = '0;
    w_inv_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    for (int i = 3; i >= 0; i--) begin
      w_hit_vec[i] = w_line[i][VB] && (w_line[i][TAG_W-1:0] == r_tag);
      w_inv_vec[i] = !w_line[i][VB];
      if (w_hit_vec[i]) w_hit_way = 2'(i);
      if (w_inv_vec[i]) w_inv_way = 2'(i);
    end
  end

  // PLRU bits per set: [0]=b0 (half select), [1]=b1 (ways 0/1), [2]=b2 (ways 2/3)
  assign w_hit         = |w_hit_vec;
  assign w_plru        = r_plru[r_index];
  assign w_plru_way    = w_plru[0] ? (w_plru[2] ? 2'd3 : 2'd2)
                                   : (w_plru[1] ? 2'd1 : 2'd0);
  assign w_victim_way  = (|w_inv_vec) ? w_inv_way : w_plru_way;
  assign w_victim_line = w_line[w_victim_way];
  assign w_victim_wb   = w_victim_line[VB] & w_victim_line[DB];

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
    case (way)
      2'd0:    plru_touch = {p[2], 1'b1, 1'b1};
      2'd1:    plru_touch = {p[2], 1'b0, 1'b1};
      2'd2:    plru_touch = {1'b1, p[1], 1'b0};
      default: plru_touch = {1'b0, p[1], 1'b0};
    endcase
  endfunction

  always_ff @(posedge clk or negedge gen_reset) begin
    if (!gen_reset) begin
      r_state             <= S_IDLE;
      r_write             <= 1'b0;
      r_index             <= '0;
      r_tag               <= '0;
      r_hit               <= 1'b0;
      r_way               <= '0;
      for (int s = 0; s < SETS; s++) r_plru[s] <= 3'b000;
      r_req_ready         <= 1'b1;
      r_tags_read_enable  <= 1'b0;
      r_tags_adress       <= '0;
      r_tags_data_in      <= '0;
      r_tags_write_enable <= '0;
      r_resp_valid        <= 1'b0;
      r_resp_hit          <= 1'b0;
      r_resp_way          <= '0;
      r_fill_req_valid    <= 1'b0;
      r_fill_req_wb       <= 1'b0;
      r_fill_req_tag      <= '0;
      r_fill_req_index    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write            <= req_write;
            r_index            <= req_index;
            r_tag              <= req_tag;
            r_req_ready        <= 1'b0;
            r_tags_read_enable <= 1'b1;
            r_tags_adress      <= req_index;
            r_state            <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_tags_read_enable <= 1'b0;
          r_state            <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_hit <= 1'b1;
            r_way <= w_hit_way;
            if (r_write) begin
              r_tags_write_enable <= 4'b0001 << w_hit_way;
              r_tags_data_in      <= {1'b1, 1'b1, r_tag};
              r_state             <= S_UPDATE;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_hit   <= 1'b1;
              r_resp_way   <= w_hit_way;
              r_state      <= S_RESP;
            end
          end else begin
            r_hit            <= 1'b0;
            r_way            <= w_victim_way;
            r_fill_req_valid <= 1'b1;
            r_fill_req_wb    <= w_victim_wb;
            r_fill_req_tag   <= w_victim_wb ? w_victim_line[TAG_W-1:0] : r_tag;
            r_fill_req_index <= r_index;
            r_state          <= S_MISS;
          end
        end
        S_MISS: begin
          if (fill_ack) begin
            r_fill_req_valid    <= 1'b0;
            r_fill_req_wb       <= 1'b0;
            r_fill_req_tag      <= '0;
            r_fill_req_index    <= '0;
            r_tags_write_enable <= 4'b0001 << r_way;
            r_tags_data_in      <= {1'b1, r_write, r_tag};
            r_state             <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_tags_write_enable <= '0;
          r_tags_data_in      <= '0;
          r_resp_valid        <= 1'b1;
          r_resp_hit          <= r_hit;
          r_resp_way          <= r_way;
          r_state             <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid     <= 1'b0;
          r_resp_hit       <= 1'b0;
          r_resp_way       <= '0;
          r_plru[r_index]  <= plru_touch(r_plru[r_index], r_way);
          r_req_ready      <= 1'b1;
          r_state          <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign tags_read_enable  = r_tags_read_enable;
  assign tags_adress       = r_tags_adress;
  assign tags_data_in      = r_tags_data_in;
  assign tags_write_enable = r_tags_write_enable;
  assign resp_valid        = r_resp_valid;
  assign resp_hit          = r_resp_hit;
  assign resp_way          = r_resp_way;
  assign fill_req_valid    = r_fill_req_valid;
  assign fill_req_wb       = r_fill_req_wb;
  assign fill_req_tag      = r_fill_req_tag;
  assign fill_req_index    = r_fill_req_index;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - randomized scoreboard bench for cache_tag_ctrl
module tb_cache_tag_ctrl;
  localparam int BD = 10, SL = 37, TW = 35, SETS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic gen_reset, req_valid, req_ready, req_write;
  logic [BD-1:0] req_index, tags_adress, fill_req_index;
  logic [TW-1:0] req_tag, fill_req_tag;
  logic tags_read_enable, resp_valid, resp_hit, fill_req_valid, fill_req_wb, fill_ack;
  logic [SL-1:0] tags_data_in, tags_data_out1, tags_data_out2, tags_data_out3, tags_data_out4;
  logic [3:0] tags_write_enable;
  logic [1:0] resp_way;

  cache_tag_ctrl dut (
    .clk(clk), .gen_reset(gen_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_index(req_index), .req_tag(req_tag),
    .tags_read_enable(tags_read_enable), .tags_adress(tags_adress),
    .tags_data_in(tags_data_in), .tags_write_enable(tags_write_enable),
    .tags_data_out1(tags_data_out1), .tags_data_out2(tags_data_out2),
    .tags_data_out3(tags_data_out3), .tags_data_out4(tags_data_out4),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .fill_req_valid(fill_req_valid), .fill_req_wb(fill_req_wb),
    .fill_req_tag(fill_req_tag), .fill_req_index(fill_req_index), .fill_ack(fill_ack)
  );

  // External 4-way tag set: registered read, per-way write strobes
  logic [SL-1:0] mem [4][SETS] = '{default: '0};
  logic [SL-1:0] rd [4] = '{default: '0};
  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (tags_read_enable) rd[w] <= mem[w][tags_adress];
      if (tags_write_enable[w]) mem[w][tags_adress] <= tags_data_in;
    end
  end
  assign tags_data_out1 = rd[0];
  assign tags_data_out2 = rd[1];
  assign tags_data_out3 = rd[2];
  assign tags_data_out4 = rd[3];

  int total = 0, bad = 0, cyc = 0, n_exp = 0, n_resp = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { bit hit; logic [1:0] way; int lat; int acc; } resp_t;
  typedef struct { bit wb; logic [TW-1:0] tag; logic [BD-1:0] idx; } fill_t;
  typedef struct { logic [3:0] we; logic [SL-1:0] data; logic [BD-1:0] idx; } wr_t;
  resp_t rq[$];
  fill_t fq[$];
  wr_t   wq[$];

  // Reference cache: per-set way contents and tree bits b0/b1/b2
  bit            ref_v [SETS][4];
  bit            ref_d [SETS][4];
  bit [TW-1:0]   ref_t [SETS][4];
  bit [2:0]      ref_p [SETS];

  function automatic void predict(input int idx, input logic [TW-1:0] tag,
                                  output bit hit, output logic [1:0] way,
                                  output bit wb, output logic [TW-1:0] ftag);
    int inv;
    hit = 0; way = 0; inv = -1;
    for (int w = 3; w >= 0; w--)
      if (ref_v[idx][w] && ref_t[idx][w] == tag) begin hit = 1; way = 2'(w); end
    if (!hit) begin
      for (int w = 3; w >= 0; w--) if (!ref_v[idx][w]) inv = w;
      if (inv >= 0) way = 2'(inv);
      else if (ref_p[idx][0]) way = ref_p[idx][2] ? 2'd3 : 2'd2;
      else way = ref_p[idx][1] ? 2'd1 : 2'd0;
    end
    wb = !hit && ref_v[idx][way] && ref_d[idx][way];
    ftag = wb ? ref_t[idx][way] : tag;
  endfunction

  function automatic void commit(input int idx, input logic [TW-1:0] tag, input bit wr,
                                 input bit hit, input logic [1:0] way);
    if (!hit || wr) begin
      ref_v[idx][way] = 1; ref_d[idx][way] = wr; ref_t[idx][way] = tag;
    end
    if (way < 2) begin ref_p[idx][0] = 1; ref_p[idx][1] = (way == 0); end
    else         begin ref_p[idx][0] = 0; ref_p[idx][2] = (way == 2); end
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    check("ready_wait", req_ready, 1);
  endtask

  task automatic issue(input int idx, input logic [TW-1:0] tag, input bit wr,
                       input int dwell, input bit hold);
    bit hit, wb; logic [1:0] way; logic [TW-1:0] ftag; int n;
    resp_t r; fill_t f; wr_t x;
    predict(idx, tag, hit, way, wb, ftag);
    wait_ready();
    if (!req_ready) return;
    req_valid = 1; req_write = wr; req_index = BD'(idx); req_tag = tag;
    r.hit = hit; r.way = way; r.acc = cyc; r.lat = hit ? (wr ? 4 : 3) : 4 + dwell;
    rq.push_back(r); n_exp++;
    if (!hit) begin f.wb = wb; f.tag = ftag; f.idx = BD'(idx); fq.push_back(f); end
    if (!hit || wr) begin
      x.we = 4'b0001 << way; x.data = {1'b1, wr, tag}; x.idx = BD'(idx); wq.push_back(x);
    end
    commit(idx, tag, wr, hit, way);
    @(negedge clk);
    if (!hold) req_valid = 0;
    if (!hit) begin
      n = 0;
      while (!fill_req_valid && n < 20) begin @(negedge clk); n++; end
      check("fill_wait", fill_req_valid, 1);
      if (fill_req_valid) begin
        repeat (dwell - 1) @(negedge clk);
        fill_ack = 1;
        @(negedge clk);
        fill_ack = 0;
      end
    end
    if (hold) begin
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      check("resp_wait", resp_valid, 1);
      req_valid = 0;
    end
  endtask

  always @(negedge clk) begin
    if (gen_reset && resp_valid) begin
      n_resp++;
      if (rq.size() == 0) check("unexpected_resp", resp_valid, 0);
      else begin
        resp_t r;
        r = rq.pop_front();
        check("resp_hit", resp_hit, r.hit);
        check("resp_way", resp_way, r.way);
        check("resp_latency", cyc - r.acc, r.lat);
      end
    end
  end

  logic prev_fill = 1'b0;
  always @(negedge clk) begin
    if (gen_reset && fill_req_valid && !prev_fill) begin
      if (fq.size() == 0) check("unexpected_fill", fill_req_valid, 0);
      else begin
        fill_t f;
        f = fq.pop_front();
        check("fill_wb", fill_req_wb, f.wb);
        check("fill_tag", fill_req_tag, f.tag);
        check("fill_index", fill_req_index, f.idx);
      end
    end
    prev_fill <= fill_req_valid;
  end

  always @(negedge clk) begin
    if (gen_reset && tags_write_enable != 4'b0) begin
      if (wq.size() == 0) check("unexpected_write", tags_write_enable, 0);
      else begin
        wr_t x;
        x = wq.pop_front();
        check("write_en", tags_write_enable, x.we);
        check("write_data", tags_data_in, x.data);
        check("write_addr", tags_adress, x.idx);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || !req_ready) && n < 40) begin @(negedge clk); n++; end
    check("drain", rq.size(), 0);
  endtask

  logic [TW-1:0] pool [6];
  logic [63:0]   rnd;

  initial begin
    bit hit, wb; logic [1:0] way; logic [TW-1:0] ftag; int n; fill_t f;
    gen_reset = 0; req_valid = 0; req_write = 0; req_index = '0; req_tag = '0; fill_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fill_valid", fill_req_valid, 0);
    check("rst_write_en", tags_write_enable, 0);
    check("rst_read_en", tags_read_enable, 0);
    gen_reset = 1;

    issue(5, 35'h1234, 0, 3, 0);
    issue(5, 35'h1234, 0, 1, 0);
    issue(5, 35'h2_0000_0001, 0, 1, 0);
    issue(5, 35'h2_0000_0002, 0, 2, 0);
    issue(5, 35'h2_0000_0003, 0, 1, 0);
    issue(5, 35'h1234, 0, 1, 0);
    issue(5, 35'h3_0000_0005, 0, 2, 0);

    issue(9, 35'h0F0F, 1, 1, 0);
    issue(9, 35'h0AA1, 0, 2, 0);
    issue(9, 35'h0AA2, 0, 2, 0);
    issue(9, 35'h0AA3, 0, 2, 0);
    issue(9, 35'h0AA1, 0, 1, 0);
    issue(9, 35'h0AA2, 0, 1, 0);
    issue(9, 35'h0AA3, 0, 1, 0);
    issue(9, 35'h0BB4, 0, 1, 0);
    issue(9, 35'h0AA1, 1, 1, 0);
    drain();

    // Abort a pending fill with reset; the set must stay untouched
    predict(77, 35'h7777, hit, way, wb, ftag);
    wait_ready();
    req_valid = 1; req_write = 0; req_index = 10'd77; req_tag = 35'h7777;
    f.wb = wb; f.tag = ftag; f.idx = 10'd77; fq.push_back(f);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!fill_req_valid && n < 20) begin @(negedge clk); n++; end
    check("abort_fill_wait", fill_req_valid, 1);
    #2 gen_reset = 0;
    #1;
    check("abort_fill_drop", fill_req_valid, 0);
    check("abort_no_write", tags_write_enable, 0);
    check("abort_ready", req_ready, 1);
    for (int s = 0; s < SETS; s++) ref_p[s] = 3'b000;
    rq.delete(); wq.delete();
    repeat (2) @(negedge clk);
    gen_reset = 1;
    @(negedge clk);
    fill_ack = 1;
    @(negedge clk);
    fill_ack = 0;
    @(negedge clk);
    check("stray_ack_ready", req_ready, 1);
    check("stray_ack_fill", fill_req_valid, 0);
    issue(77, 35'h7777, 0, 2, 1);
    issue(77, 35'h7777, 0, 1, 1);
    repeat (10) @(negedge clk);
    check("resp_count", n_resp, n_exp);

    for (int i = 0; i < 6; i++) begin
      rnd = {$urandom(), $urandom()};
      pool[i] = rnd[TW-1:0];
    end
    for (int i = 0; i < 200; i++) begin
      int sel, idx;
      sel = $urandom_range(0, 3);
      idx = (sel == 0) ? 5 : (sel == 1) ? 9 : (sel == 2) ? 77 : int'($urandom_range(0, SETS - 1));
      issue(idx, pool[$urandom_range(0, 5)], bit'($urandom_range(0, 1)),
            int'($urandom_range(1, 4)), bit'($urandom_range(0, 7) == 0));
    end
    drain();
    repeat (5) @(negedge clk);
    check("resp_count_final", n_resp, n_exp);
    check("fill_queue_empty", fq.size(), 0);
    check("write_queue_empty", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
